// File: rtl/clock_pkg.sv
// clock_pkg: shared FSM states, BCD field slices/limits and the snooze minute adder.
package clock_pkg;
    typedef enum logic [2:0] {
        RUN,
        SET_TIME_HR,
        SET_TIME_MIN,
        SET_ALARM_HR,
        SET_ALARM_MIN
    } state_t;
    localparam int HH_HI = 23;
    localparam int HH_LO = 16;
    localparam int MM_HI = 15;
    localparam int MM_LO = 8;
    localparam int SS_HI = 7;
    localparam int SS_LO = 0;
    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;
    // Adds n (0..59) minutes to a BCD minute field; returns {carry_into_hour, bcd_minutes}.
    function automatic logic [8:0] bcd_add_min(input logic [7:0] mm, input logic [6:0] n);
        logic [6:0] s;
        logic       c;
        s = 7'(mm[7:4]) * 7'd10 + 7'(mm[3:0]) + n;
        c = s >= 7'd60;
        if (c) s = s - 7'd60;
        return {c, 4'(s / 7'd10), 4'(s % 7'd10)};
    endfunction
endpackage

// File: rtl/clock_mode_controller_if.sv
// clock_mode_controller_if: button/tick inputs and time/control outputs of the mode controller.
//   master: front end side (drives ticks, buttons, ringing flag; reads time words and controls)
//   slave : controller side (reverse directions)
interface clock_mode_controller_if;
    logic        tick_1hz;
    logic        mode_btn;
    logic        next_btn;
    logic        inc_btn;
    logic        alarm_btn;
    logic        alarm_went_off;
    logic [31:0] current_time;
    logic [31:0] alarm_time;
    logic        time_set;
    logic        alarm_set;
    logic        alarm_on;
    logic        alarm_reset;
    modport master (
        output tick_1hz, mode_btn, next_btn, inc_btn, alarm_btn, alarm_went_off,
        input  current_time, alarm_time, time_set, alarm_set, alarm_on, alarm_reset
    );
    modport slave (
        input  tick_1hz, mode_btn, next_btn, inc_btn, alarm_btn, alarm_went_off,
        output current_time, alarm_time, time_set, alarm_set, alarm_on, alarm_reset
    );
endinterface

// File: rtl/bcd_field_inc.sv
// bcd_field_inc: combinational two-digit BCD increment that wraps to 00 after limit.
//   val   : current BCD field
//   limit : last legal value (8'h23 or 8'h59)
//   nxt   : incremented/wrapped field
//   carry : high when val is at limit (wrap occurs)
module bcd_field_inc (
    input  logic [7:0] val,
    input  logic [7:0] limit,
    output logic [7:0] nxt,
    output logic       carry
);
    always_comb begin
        carry = val == limit;
        nxt   = carry ? 8'h00 : (val[3:0] == 4'h9) ? {val[7:4] + 4'h1, 4'h0} : val + 8'h01;
    end
endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller: button-driven sequencer owning the BCD time-of-day counter and alarm register.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of clock_mode_controller_if (tick, buttons, ringing flag in;
//           current_time, alarm_time, time_set, alarm_set, alarm_on, alarm_reset out)
module clock_mode_controller
    import clock_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN    = 9,
    parameter logic [31:0] ALARM_DEFAULT = 32'h0006_0000
) (
    input logic                    clk,
    input logic                    reset,
    clock_mode_controller_if.slave bus
);
    state_t      state;
    logic [23:0] now;
    logic [15:0] alarm_prog;
    logic [31:0] alarm_time;
    logic        snooze_active;
    logic        alarm_on;
    logic        alarm_reset;
    logic        time_set;
    logic        alarm_set;
    logic        m, n, i, a, ringing, set_time;
    logic [7:0]  ss_n, mm_n, hh_n, eh_n, em_n, sh_n;
    logic        ss_c, mm_c, hh_c, eh_c, em_c, sh_c;
    logic [7:0]  eh_in, em_in, snz_hh;
    logic [8:0]  snz_mm;
    logic [23:0] ticked;
    logic [31:0] prog_word;
    logic        unused_carry;

    // Only the highest-priority button of a simultaneous group is acted on.
    assign m = bus.mode_btn;
    assign n = bus.next_btn & ~m;
    assign i = bus.inc_btn & ~m & ~bus.next_btn;
    assign a = bus.alarm_btn & ~m & ~bus.next_btn & ~bus.inc_btn;
    assign ringing  = (state == RUN) & bus.alarm_went_off;
    assign set_time = (state == SET_TIME_HR) | (state == SET_TIME_MIN);

    bcd_field_inc u_ss (.val(now[SS_HI:SS_LO]), .limit(MS_MAX), .nxt(ss_n), .carry(ss_c));
    bcd_field_inc u_mm (.val(now[MM_HI:MM_LO]), .limit(MS_MAX), .nxt(mm_n), .carry(mm_c));
    bcd_field_inc u_hh (.val(now[HH_HI:HH_LO]), .limit(HH_MAX), .nxt(hh_n), .carry(hh_c));

    // One shared edit incrementer pair serves whichever group (time or alarm) is being set.
    assign eh_in = set_time ? now[HH_HI:HH_LO] : alarm_prog[15:8];
    assign em_in = set_time ? now[MM_HI:MM_LO] : alarm_prog[7:0];
    bcd_field_inc u_eh (.val(eh_in), .limit(HH_MAX), .nxt(eh_n), .carry(eh_c));
    bcd_field_inc u_em (.val(em_in), .limit(MS_MAX), .nxt(em_n), .carry(em_c));

    assign snz_mm = bcd_add_min(now[MM_HI:MM_LO], 7'(SNOOZE_MIN));
    bcd_field_inc u_sh (.val(now[HH_HI:HH_LO]), .limit(HH_MAX), .nxt(sh_n), .carry(sh_c));
    assign snz_hh = snz_mm[8] ? sh_n : now[HH_HI:HH_LO];

    assign ticked    = {(ss_c & mm_c) ? hh_n : now[HH_HI:HH_LO], ss_c ? mm_n : now[MM_HI:MM_LO], ss_n};
    assign prog_word = {8'h00, alarm_prog, 8'h00};
    assign unused_carry = hh_c ^ eh_c ^ em_c ^ sh_c;

    // alarm_time is kept as its own register so it always shows the snooze target
    // while snoozing and the programmed alarm otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            now           <= '0;
            alarm_prog    <= ALARM_DEFAULT[23:8];
            alarm_time    <= {8'h00, ALARM_DEFAULT[23:8], 8'h00};
            snooze_active <= 1'b0;
            alarm_on      <= 1'b0;
            alarm_reset   <= 1'b0;
            time_set      <= 1'b0;
            alarm_set     <= 1'b0;
        end else begin
            alarm_reset <= 1'b0;
            if (bus.tick_1hz && !set_time) now <= ticked;
            case (state)
                RUN: begin
                    if (ringing) begin
                        if (m || i || a) alarm_reset <= 1'b1;
                        if (m) begin
                            snooze_active <= 1'b0;
                            alarm_time    <= prog_word;
                        end else if (i) begin
                            snooze_active <= 1'b1;
                            alarm_time    <= {8'h00, snz_hh, snz_mm[7:0], 8'h00};
                        end else if (a) begin
                            alarm_on <= 1'b0;
                        end
                    end else if (m) begin
                        state    <= SET_TIME_HR;
                        time_set <= 1'b1;
                    end else if (a) begin
                        alarm_on      <= ~alarm_on;
                        snooze_active <= 1'b0;
                        alarm_time    <= prog_word;
                    end
                end
                SET_TIME_HR, SET_TIME_MIN: begin
                    if (m) begin
                        state              <= SET_ALARM_HR;
                        time_set           <= 1'b0;
                        alarm_set          <= 1'b1;
                        now[SS_HI:SS_LO]   <= 8'h00;
                        snooze_active      <= 1'b0;
                        alarm_time         <= prog_word;
                    end else if (n) begin
                        state <= (state == SET_TIME_HR) ? SET_TIME_MIN : SET_TIME_HR;
                    end else if (i) begin
                        if (state == SET_TIME_HR) now[HH_HI:HH_LO] <= eh_n;
                        else now[MM_HI:MM_LO] <= em_n;
                    end
                end
                SET_ALARM_HR, SET_ALARM_MIN: begin
                    if (m) begin
                        state     <= RUN;
                        alarm_set <= 1'b0;
                    end else if (n) begin
                        state <= (state == SET_ALARM_HR) ? SET_ALARM_MIN : SET_ALARM_HR;
                    end else if (i) begin
                        if (state == SET_ALARM_HR) begin
                            alarm_prog[15:8]  <= eh_n;
                            alarm_time[23:16] <= eh_n;
                        end else begin
                            alarm_prog[7:0]   <= em_n;
                            alarm_time[15:8]  <= em_n;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.current_time = {8'h00, now};
    assign bus.alarm_time   = alarm_time;
    assign bus.time_set     = time_set;
    assign bus.alarm_set    = alarm_set;
    assign bus.alarm_on     = alarm_on;
    assign bus.alarm_reset  = alarm_reset;
endmodule

// File: tb/tb_clock_mode_controller.sv
// tb_clock_mode_controller: directed scoreboard bench for clock_mode_controller.
module tb_clock_mode_controller;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    clock_mode_controller_if bus_if ();
    clock_mode_controller dut (.clk(clk), .reset(reset), .bus(bus_if));
    always #5 clk = ~clk;

    localparam logic [4:0] M = 5'b10000, N = 5'b01000, I = 5'b00100, A = 5'b00010, T = 5'b00001, Z = 5'b00000;
    localparam int CUR = 0, ALM = 1, TS = 2, AS = 3, ON = 4, AR = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int passed = 0;
    int total  = 0;

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            CUR:     return bus_if.current_time;
            ALM:     return bus_if.alarm_time;
            TS:      return {31'b0, bus_if.time_set};
            AS:      return {31'b0, bus_if.alarm_set};
            ON:      return {31'b0, bus_if.alarm_on};
            default: return {31'b0, bus_if.alarm_reset};
        endcase
    endfunction

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.val) passed++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    // Drives {mode,next,inc,alarm,tick} for one cycle from a negedge; returns at the next negedge.
    task automatic step(input logic [4:0] b);
        {bus_if.mode_btn, bus_if.next_btn, bus_if.inc_btn, bus_if.alarm_btn, bus_if.tick_1hz} = b;
        @(negedge clk);
        {bus_if.mode_btn, bus_if.next_btn, bus_if.inc_btn, bus_if.alarm_btn, bus_if.tick_1hz} = Z;
    endtask

    task automatic steps(input logic [4:0] b, input int k);
        for (int j = 0; j < k; j++) step(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        {bus_if.mode_btn, bus_if.next_btn, bus_if.inc_btn, bus_if.alarm_btn, bus_if.tick_1hz} = Z;
        bus_if.alarm_went_off = 1'b0;
        repeat (2) @(negedge clk);
        expect_val("reset_cur", CUR, 32'h0);
        expect_val("reset_alm", ALM, 32'h0006_0000);
        expect_val("reset_ts", TS, 0);
        expect_val("reset_as", AS, 0);
        expect_val("reset_on", ON, 0);
        expect_val("reset_ar", AR, 0);
        check();
        reset = 1'b1;

        steps(T, 61);
        expect_val("tick61_cur", CUR, 32'h0000_0101);
        expect_val("tick61_alm", ALM, 32'h0006_0000);
        expect_val("tick61_ts", TS, 0);
        expect_val("tick61_as", AS, 0);
        expect_val("tick61_on", ON, 0);
        expect_val("tick61_ar", AR, 0);
        check();

        reset = 1'b0;
        #1;
        expect_val("async_reset_cur", CUR, 32'h0);
        check();
        @(negedge clk);
        reset = 1'b1;

        step(M);
        expect_val("set_time_ts", TS, 1);
        expect_val("set_time_as", AS, 0);
        check();
        steps(I, 23);
        expect_val("hh_to_23", CUR, 32'h0023_0000);
        check();
        steps(T, 3);
        expect_val("tick_frozen", CUR, 32'h0023_0000);
        check();
        step(N);
        steps(I, 59);
        expect_val("mm_to_59", CUR, 32'h0023_5900);
        check();
        step(M);
        expect_val("set_alarm_ts", TS, 0);
        expect_val("set_alarm_as", AS, 1);
        expect_val("set_alarm_cur", CUR, 32'h0023_5900);
        check();
        step(M);
        expect_val("back_run_as", AS, 0);
        check();
        steps(T, 59);
        expect_val("at_235959", CUR, 32'h0023_5959);
        check();
        step(T);
        expect_val("midnight_wrap", CUR, 32'h0);
        check();

        step(M);
        steps(I, 3);
        expect_val("edit_ts_high", TS, 1);
        check();
        step(N);
        steps(I, 2);
        step(M);
        step(M);
        expect_val("edit_result", CUR, 32'h0003_0200);
        expect_val("edit_ts_low", TS, 0);
        expect_val("edit_as_low", AS, 0);
        check();

        step(M);
        step(N);
        steps(I, 57);
        expect_val("mm_59_again", CUR, 32'h0003_5900);
        check();
        step(I);
        expect_val("mm_wrap_no_carry", CUR, 32'h0003_0000);
        check();
        step(T);
        expect_val("tick_in_set_min", CUR, 32'h0003_0000);
        check();
        step(N);
        steps(I, 20);
        expect_val("hh_23_again", CUR, 32'h0023_0000);
        check();
        step(I);
        expect_val("hh_wrap", CUR, 32'h0);
        check();
        step(M);
        step(M);

        step(M);
        steps(I, 6);
        step(M);
        step(M);
        expect_val("at_0600", CUR, 32'h0006_0000);
        check();
        step(A);
        expect_val("arm_on", ON, 1);
        check();
        bus_if.alarm_went_off = 1'b1;
        step(I);
        expect_val("snooze_ar", AR, 1);
        expect_val("snooze_alm", ALM, 32'h0006_0900);
        expect_val("snooze_on", ON, 1);
        expect_val("snooze_ts", TS, 0);
        check();
        bus_if.alarm_went_off = 1'b0;
        step(Z);
        expect_val("snooze_ar_pulse_end", AR, 0);
        expect_val("snooze_alm_held", ALM, 32'h0006_0900);
        check();
        bus_if.alarm_went_off = 1'b1;
        step(M);
        expect_val("dismiss_ar", AR, 1);
        expect_val("dismiss_alm", ALM, 32'h0006_0000);
        expect_val("dismiss_ts", TS, 0);
        check();
        bus_if.alarm_went_off = 1'b0;

        step(M);
        steps(I, 17);
        step(N);
        steps(I, 55);
        step(M);
        step(M);
        expect_val("at_2355", CUR, 32'h0023_5500);
        check();
        bus_if.alarm_went_off = 1'b1;
        step(I);
        expect_val("snooze_wrap_alm", ALM, 32'h0000_0400);
        check();
        step(A);
        expect_val("ring_alarm_btn_ar", AR, 1);
        expect_val("ring_alarm_btn_on", ON, 0);
        check();
        bus_if.alarm_went_off = 1'b0;
        step(A);
        expect_val("rearm_on", ON, 1);
        expect_val("rearm_alm", ALM, 32'h0006_0000);
        expect_val("rearm_ar", AR, 0);
        check();

        step(M | I);
        expect_val("mode_inc_ts", TS, 1);
        expect_val("mode_inc_cur", CUR, 32'h0023_5500);
        check();
        step(N | I);
        expect_val("next_inc_cur", CUR, 32'h0023_5500);
        check();
        step(I);
        expect_val("in_min_after_next", CUR, 32'h0023_5600);
        check();
        step(M);
        step(M);
        step(T | I);
        expect_val("tick_inc_cur", CUR, 32'h0023_5601);
        expect_val("tick_inc_alm", ALM, 32'h0006_0000);
        expect_val("tick_inc_ts", TS, 0);
        check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
